truth_table_checker: RTL and testbench
======================================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter TRUTH, default 8'h01, expected DUT output per vector; bit index = {A,B,C}; default is 3-input NOR.
REQ-002 The block SHALL have exactly one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle pulse; clears results and begins a check run.
REQ-006 smp_valid  input  1  A, B, C, y hold one valid sample this cycle.
REQ-007 A, B, C  input  1 each  vector applied to the DUT; A is the MSB.
REQ-008 y  input  1  DUT response to {A,B,C}.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  high in DONE when err_cnt == 0.
REQ-012 err_cnt  output  4  mismatch count, saturating.
REQ-013 first_err_vec  output  3  {A,B,C} of the first mismatch in the run.
REQ-014 first_err_valid  output  1  first_err_vec holds a captured value.
REQ-015 cov  output  8  coverage bitmap; bit {A,B,C} set once that vector is sampled.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-017 IDLE -> RUN on start; RUN -> DONE on the edge at which cov becomes 8'hFF; DONE -> RUN on start; no other transitions.
REQ-018 start in any state SHALL clear cov, err_cnt, first_err_vec, first_err_valid at the same edge and enter RUN.
REQ-019 In RUN, on each edge with smp_valid=1, the block SHALL compare y with TRUTH[{A,B,C}].
REQ-020 Mismatch: err_cnt increments (holds at 4'hF); if first_err_valid=0, first_err_vec <= {A,B,C} and first_err_valid <= 1.
REQ-021 Every RUN sample SHALL set cov[{A,B,C}]; repeated vectors are compared and counted but do not change cov.
REQ-022 Latency: results of a sample SHALL be visible on outputs one clock after the sampling edge; done asserts in the cycle after the sample completing coverage.
REQ-023 smp_valid in IDLE or DONE SHALL be ignored; all results hold.
REQ-024 start and smp_valid together: start wins; that sample is discarded.
REQ-025 pass SHALL be combinational from state and err_cnt and be 0 outside DONE.
REQ-026 All outputs SHALL be registered or decoded from registered state; no combinational path from A, B, C, y to outputs.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0, cov=0, regardless of clk.
REQ-028 Reset mid-run SHALL abandon the run; after release the block waits in IDLE for start.

Verification
REQ-029 Reset, start, samples 000..111 with y = NOR(A,B,C), one per cycle -> done=1 one cycle after the 8th, pass=1, err_cnt=0, cov=8'hFF.
REQ-030 Same sweep with y forced 0 at 000 and 1 at 101 -> err_cnt=2, first_err_vec=3'b000, first_err_valid=1, pass=0.
REQ-031 Start, 20 samples of vector 011 with y=1, then 000..111 correct -> err_cnt=4'hF, done only after final vector, first_err_vec=3'b011.
REQ-032 Start, 4 vectors, rst_n pulsed low between clock edges -> all outputs 0 immediately; samples after release ignored until start.
REQ-033 In DONE: smp_valid with wrong y -> no output change; start and smp_valid same cycle -> busy=1, cov=0, err_cnt=0.
REQ-034 TRUTH=8'h80 (AND3), correct AND responses -> pass=1; NOR responses -> err_cnt=2, first_err_vec=3'b000.

Source files
------------

// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Purpose:
//   Watches a stream of {A,B,C} vectors and the response y of some
//   combinational block under test.  Each response is compared against the
//   TRUTH parameter.  The checker counts mismatches, remembers the first
//   failing vector and tracks which of the eight vectors have been seen.
//   A run begins on start and is complete once every vector has been seen.
//
// Parameters:
//   TRUTH            expected y for each vector, bit index = {A,B,C}
//                    (default 8'h01 = 3-input NOR)
//
// Ports:
//   clk              rising-edge clock for all state
//   rst_n            asynchronous active-low reset
//   start            single-cycle pulse: clear results, begin a run
//   smp_valid        A, B, C, y carry one valid sample this cycle
//   A, B, C          vector applied to the block under test (A is the MSB)
//   y                response of the block under test
//   busy             high while a run is in progress
//   done             high once the run has covered every vector
//   pass             high in done when no mismatch was seen
//   err_cnt          mismatch count, saturates at 4'hF
//   first_err_vec    {A,B,C} of the first mismatch in the run
//   first_err_valid  first_err_vec holds a captured vector
//   cov              coverage bitmap, bit {A,B,C} set once that vector is seen
// ---------------------------------------------------------------------------
module truth_table_checker #(
    parameter logic [7:0] TRUTH = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       smp_valid,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err_vec,
    output logic       first_err_valid,
    output logic [7:0] cov
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } checkState_t;

    checkState_t state_q, state_d;
    logic [3:0]  errCnt_q, errCnt_d;
    logic [2:0]  firstErrVec_q, firstErrVec_d;
    logic        firstErrValid_q, firstErrValid_d;
    logic [7:0]  cov_q, cov_d;

    logic [2:0]  sampleVec;
    logic [7:0]  covWithSample;
    logic        sampleMismatch;

    assign sampleVec      = {A, B, C};
    assign covWithSample  = cov_q | (8'd1 << sampleVec);
    assign sampleMismatch = (y != TRUTH[sampleVec]);

    // Next-state and result update.  A start pulse takes priority over
    // everything, including a sample presented in the same cycle, so a new
    // run always begins from cleared results.  Samples only count while a run
    // is in progress; in IDLE and DONE they fall through to the hold defaults.
    // The run finishes on the very edge whose sample fills the coverage map.
    always_comb begin
        state_d         = state_q;
        errCnt_d        = errCnt_q;
        firstErrVec_d   = firstErrVec_q;
        firstErrValid_d = firstErrValid_q;
        cov_d           = cov_q;

        if (start) begin
            state_d         = RUN;
            errCnt_d        = 4'd0;
            firstErrVec_d   = 3'd0;
            firstErrValid_d = 1'b0;
            cov_d           = 8'd0;
        end else if (state_q == RUN && smp_valid) begin
            cov_d = covWithSample;
            if (sampleMismatch) begin
                if (errCnt_q != 4'hF) begin
                    errCnt_d = errCnt_q + 4'd1;
                end
                if (!firstErrValid_q) begin
                    firstErrVec_d   = sampleVec;
                    firstErrValid_d = 1'b1;
                end
            end
            if (covWithSample == 8'hFF) begin
                state_d = DONE;
            end
        end
    end

    // State and result registers.  Reset abandons any run and returns to
    // IDLE with every result cleared, independent of the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            errCnt_q        <= 4'd0;
            firstErrVec_q   <= 3'd0;
            firstErrValid_q <= 1'b0;
            cov_q           <= 8'd0;
        end else begin
            state_q         <= state_d;
            errCnt_q        <= errCnt_d;
            firstErrVec_q   <= firstErrVec_d;
            firstErrValid_q <= firstErrValid_d;
            cov_q           <= cov_d;
        end
    end

    // Outputs come straight from registers or a decode of the state, so the
    // sample inputs never reach an output combinationally.
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = (state_q == DONE) && (errCnt_q == 4'd0);
    assign err_cnt         = errCnt_q;
    assign first_err_vec   = firstErrVec_q;
    assign first_err_valid = firstErrValid_q;
    assign cov             = cov_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// ---------------------------------------------------------------------------
// tb_truth_table_checker
//
// Drives two checkers side by side from the same stimulus: one with the
// default NOR table and one built for AND3.  A reference model of both
// checkers, kept in terms of "which vectors were seen", "how many errors"
// and "which vector failed first", predicts every output each cycle.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_truth_table_checker;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start     = 1'b0;
    logic smp_valid = 1'b0;
    logic A         = 1'b0;
    logic B         = 1'b0;
    logic C         = 1'b0;
    logic y         = 1'b0;

    logic [1:0] busyV;
    logic [1:0] doneV;
    logic [1:0] passV;
    logic [3:0] errV [2];
    logic [2:0] fevV [2];
    logic [1:0] fvalV;
    logic [7:0] covV [2];

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    // Reference model state: 0 = idle, 1 = running, 2 = finished.
    int mPhase [2];
    int mErr   [2];
    int mFirst [2];
    bit mFv    [2];
    bit mSeen  [2][8];

    truth_table_checker dutNor (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
        .A(A), .B(B), .C(C), .y(y),
        .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .err_cnt(errV[0]), .first_err_vec(fevV[0]),
        .first_err_valid(fvalV[0]), .cov(covV[0])
    );

    truth_table_checker #(.TRUTH(8'h80)) dutAnd (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
        .A(A), .B(B), .C(C), .y(y),
        .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .err_cnt(errV[1]), .first_err_vec(fevV[1]),
        .first_err_valid(fvalV[1]), .cov(covV[1])
    );

    always #5 clk = ~clk;

    // The gate each checker expects, written as the logic function itself.
    function automatic bit modelTruth(input int k, input bit a, input bit b, input bit c);
        if (k == 0) return !(a || b || c);
        return a && b && c;
    endfunction

    // Number of distinct vectors seen once vector v is added.
    function automatic int seenAfter(input int k, input int v);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (mSeen[k][i] || i == v) n++;
        end
        return n;
    endfunction

    function automatic int modelCov(input int k);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            if (mSeen[k][i]) c = c | (1 << i);
        end
        return c;
    endfunction

    // Reference model update on each clock edge and on reset.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mPhase[k] <= 0;
                mErr[k]   <= 0;
                mFirst[k] <= 0;
                mFv[k]    <= 1'b0;
                for (int i = 0; i < 8; i++) mSeen[k][i] <= 1'b0;
            end else if (start) begin
                mPhase[k] <= 1;
                mErr[k]   <= 0;
                mFirst[k] <= 0;
                mFv[k]    <= 1'b0;
                for (int i = 0; i < 8; i++) mSeen[k][i] <= 1'b0;
            end else if (mPhase[k] == 1 && smp_valid) begin
                if (y != modelTruth(k, A, B, C)) begin
                    if (mErr[k] < 15) mErr[k] <= mErr[k] + 1;
                    if (!mFv[k]) begin
                        mFirst[k] <= 4 * int'(A) + 2 * int'(B) + int'(C);
                        mFv[k]    <= 1'b1;
                    end
                end
                mSeen[k][4 * int'(A) + 2 * int'(B) + int'(C)] <= 1'b1;
                if (seenAfter(k, 4 * int'(A) + 2 * int'(B) + int'(C)) == 8) mPhase[k] <= 2;
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, both checkers against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("dut%0d.busy", k), int'(busyV[k]), int'(mPhase[k] == 1));
                checkOutput($sformatf("dut%0d.done", k), int'(doneV[k]), int'(mPhase[k] == 2));
                checkOutput($sformatf("dut%0d.pass", k), int'(passV[k]), int'(mPhase[k] == 2 && mErr[k] == 0));
                checkOutput($sformatf("dut%0d.err_cnt", k), int'(errV[k]), mErr[k]);
                checkOutput($sformatf("dut%0d.first_err_vec", k), int'(fevV[k]), mFirst[k]);
                checkOutput($sformatf("dut%0d.first_err_valid", k), int'(fvalV[k]), int'(mFv[k]));
                checkOutput($sformatf("dut%0d.cov", k), int'(covV[k]), modelCov(k));
            end
        end
    end

    task automatic applyStimulus(input bit s, input bit v, input bit [2:0] vec, input bit yy);
        @(negedge clk);
        start     = s;
        smp_valid = v;
        {A, B, C} = vec;
        y         = yy;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    function automatic bit norOf(input bit [2:0] vec);
        return ~|vec;
    endfunction

    // Sweep 000..111 once; flipMask inverts y for the selected vectors and
    // useAnd selects AND3 responses instead of NOR responses.
    task automatic sweep(input bit [7:0] flipMask, input bit useAnd);
        bit [2:0] vec;
        bit       yy;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            yy  = useAnd ? (&vec) : norOf(vec);
            applyStimulus(1'b0, 1'b1, vec, yy ^ flipMask[i]);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic resetPulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset.busy", int'(busyV[0]), 0);
        checkOutput("reset.done", int'(doneV[0]), 0);
        checkOutput("reset.pass", int'(passV[0]), 0);
        checkOutput("reset.err_cnt", int'(errV[0]), 0);
        checkOutput("reset.first_err_vec", int'(fevV[0]), 0);
        checkOutput("reset.first_err_valid", int'(fvalV[0]), 0);
        checkOutput("reset.cov", int'(covV[0]), 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit [2:0] rv;
        bit       ry;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkEn = 1'b1;
        idleCycle();
        #1;
        checkOutput("idle.busy", int'(busyV[0]), 0);
        checkOutput("idle.cov", int'(covV[0]), 0);

        // Clean NOR sweep: NOR checker passes, AND checker sees 000 and 111 wrong.
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        sweep(8'h00, 1'b0);
        idleCycle();
        #1;
        checkOutput("nor.done", int'(doneV[0]), 1);
        checkOutput("nor.pass", int'(passV[0]), 1);
        checkOutput("nor.err_cnt", int'(errV[0]), 0);
        checkOutput("nor.cov", int'(covV[0]), 8'hFF);
        checkOutput("and_nor.err_cnt", int'(errV[1]), 2);
        checkOutput("and_nor.first_err_vec", int'(fevV[1]), 0);
        checkOutput("and_nor.pass", int'(passV[1]), 0);

        // Samples in DONE are ignored, then start wins over a same-cycle sample.
        applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
        idleCycle();
        #1;
        checkOutput("done_hold.err_cnt", int'(errV[0]), 0);
        checkOutput("done_hold.done", int'(doneV[0]), 1);
        applyStimulus(1'b1, 1'b1, 3'b000, 1'b0);
        idleCycle();
        #1;
        checkOutput("restart.busy", int'(busyV[0]), 1);
        checkOutput("restart.cov", int'(covV[0]), 0);
        checkOutput("restart.err_cnt", int'(errV[0]), 0);

        // Two wrong responses, at 000 and 101.
        sweep(8'b0010_0001, 1'b0);
        idleCycle();
        #1;
        checkOutput("err2.err_cnt", int'(errV[0]), 2);
        checkOutput("err2.first_err_vec", int'(fevV[0]), 0);
        checkOutput("err2.first_err_valid", int'(fvalV[0]), 1);
        checkOutput("err2.pass", int'(passV[0]), 0);

        // Saturation: 20 wrong samples of 011, then a clean sweep.
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 3'b011, 1'b1);
        sweep(8'h00, 1'b0);
        #1;
        checkOutput("sat.done_before_last", int'(doneV[0]), 0);
        idleCycle();
        #1;
        checkOutput("sat.err_cnt", int'(errV[0]), 15);
        checkOutput("sat.first_err_vec", int'(fevV[0]), 3);
        checkOutput("sat.done", int'(doneV[0]), 1);

        // AND responses: the AND3 checker passes.
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        sweep(8'h00, 1'b1);
        idleCycle();
        #1;
        checkOutput("and.pass", int'(passV[1]), 1);
        checkOutput("and.err_cnt", int'(errV[1]), 0);

        // Reset in the middle of a run, then samples ignored until start.
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b011, 1'b0);
        resetPulse();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 3'(i), 1'b1);
        idleCycle();
        #1;
        checkOutput("post_reset.cov", int'(covV[0]), 0);
        checkOutput("post_reset.busy", int'(busyV[0]), 0);
        checkOutput("post_reset.err_cnt", int'(errV[0]), 0);

        // Randomized traffic with occasional starts and reset pulses.
        for (int i = 0; i < 600; i++) begin
            rv = 3'($urandom_range(0, 7));
            ry = ($urandom_range(0, 5) == 0) ? !norOf(rv) : norOf(rv);
            if ($urandom_range(0, 24) == 0) ry = &rv;
            applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, rv, ry);
            if ($urandom_range(0, 149) == 0) resetPulse();
        end
        idleCycle();
        idleCycle();

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
